// File: rtl/silife_row_reader.sv
// Scans grid rows and streams each as a 16-bit SPI-style frame {3'b000, row, cells}, MSB first.
// Define SILIFE_READER_REVERSE_EN to send the cells byte bit-reversed (cells[0] first).
module silife_row_reader #(
    parameter int CLK_DIV  = 2,
    parameter int NUM_ROWS = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       start,
    output logic [4:0] row_select,
    output logic       rd_en,
    input  logic [7:0] cells,
    output logic       sclk,
    output logic       mosi,
    output logic       cs_n,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, SHIFT, GAP} state_t;

    state_t      state_q, state_d;
    logic [7:0]  div_cnt_q;
    logic [3:0]  bit_cnt_q;
    logic [14:0] frame_q;
    logic [7:0]  data_byte;
    logic [15:0] frame_d;
    logic        div_end, last_row, last_fall;

    assign div_end   = (div_cnt_q == 8'(CLK_DIV - 1));
    assign last_row  = (row_select == 5'(NUM_ROWS - 1));
    assign last_fall = div_end && sclk && (bit_cnt_q == 4'd15);
    assign rd_en     = (state_q == FETCH);

`ifdef SILIFE_READER_REVERSE_EN
    always_comb begin
        data_byte = '0;
        for (int i = 0; i < 8; i++) data_byte[i] = cells[7-i];
    end
`else
    assign data_byte = cells;
`endif

    assign frame_d = {3'b000, row_select, data_byte};

    // NOTE: every variable in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = FETCH;
            FETCH:   state_d = CAPTURE;
            CAPTURE: state_d = SHIFT;
            SHIFT:   if (last_fall) state_d = GAP;
            GAP:     if (div_end) state_d = last_row ? IDLE : FETCH;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  state_q <= IDLE;
        else if (en) state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_select <= '0;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            frame_q    <= '0;
            sclk       <= 1'b0;
            mosi       <= 1'b0;
            cs_n       <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (en) begin
            done <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    div_cnt_q  <= '0;
                    row_select <= '0;
                    if (start) busy <= 1'b1;
                end
                FETCH: ;
                CAPTURE: begin
                    frame_q   <= frame_d[14:0];
                    mosi      <= frame_d[15];
                    cs_n      <= 1'b0;
                    sclk      <= 1'b0;
                    div_cnt_q <= '0;
                    bit_cnt_q <= '0;
                end
                SHIFT: begin
                    if (div_end) begin
                        div_cnt_q <= '0;
                        sclk      <= ~sclk;
                        // Falling sclk edge: present the next lower frame bit.
                        if (sclk) begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            mosi      <= frame_q[14];
                            frame_q   <= {frame_q[13:0], 1'b0};
                            if (bit_cnt_q == 4'd15) begin
                                cs_n <= 1'b1;
                                mosi <= 1'b0;
                            end
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + 8'd1;
                    end
                end
                GAP: begin
                    if (div_end) begin
                        div_cnt_q <= '0;
                        if (last_row) begin
                            row_select <= '0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            row_select <= row_select + 5'd1;
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/silife_row_reader.md
SILIFE_ROW_READER -- requirements
Module: silife_row_reader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, sclk half-period in clk cycles (legal 1..255).
REQ-002 SHALL have parameter NUM_ROWS, default 32, number of grid rows scanned per frame set (legal 1..32).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port en  input  1  clock enable; low freezes all state and outputs.
REQ-006 SHALL have port start  input  1  request one full grid scan.
REQ-007 SHALL have port row_select  output  5  grid row address being read.
REQ-008 SHALL have port rd_en  output  1  grid read strobe.
REQ-009 SHALL have port cells  input  8  grid row data, valid the cycle after rd_en high.
REQ-010 SHALL have ports sclk, mosi, cs_n  output  1 each  serial link: clock, data, active-low frame select.
REQ-011 SHALL have ports busy  output  1  scan in progress; done  output  1  one-cycle scan-complete pulse.

Function
REQ-012 SHALL implement states IDLE, FETCH, CAPTURE, SHIFT, GAP.
REQ-013 IDLE: start high with en high -> FETCH next cycle, row_select <= 0, busy <= 1; start in any other state ignored.
REQ-014 FETCH (1 cycle): rd_en = 1, row_select held; -> CAPTURE.
REQ-015 CAPTURE (1 cycle): rd_en = 0; latch 16-bit frame {3'b000, row_select, cells}; cs_n <= 0, mosi <= frame bit 15; -> SHIFT.
REQ-016 SHIFT: sclk idle low; rises after CLK_DIV cycles, falls after another CLK_DIV; mosi advances to next lower bit on each falling edge; MSB first, 16 bits, 32*CLK_DIV cycles total.
REQ-017 After 16th falling edge: cs_n <= 1, mosi <= 0, -> GAP for CLK_DIV cycles.
REQ-018 GAP end: if row_select == NUM_ROWS-1 -> IDLE, row_select <= 0, busy <= 0, done = 1 for one cycle; else row_select <= row_select+1, -> FETCH.
REQ-019 Per-row time SHALL be exactly 2 + 33*CLK_DIV cycles; start-to-done = 1 + NUM_ROWS*(2+33*CLK_DIV) cycles.
REQ-020 row_select SHALL never exceed NUM_ROWS-1; increment SHALL not wrap through 5-bit overflow.
REQ-021 en low SHALL hold state, counters, sclk, mosi, cs_n, rd_en, done; a pending done pulse is emitted once en returns.
REQ-022 cells SHALL be sampled only in CAPTURE; changes at other times have no effect on the frame in flight.

Reset
REQ-023 rst_n low SHALL immediately force: state IDLE, row_select 0, rd_en 0, sclk 0, mosi 0, cs_n 1, busy 0, done 0, all counters 0.
REQ-024 Reset mid-frame SHALL abort the frame (cs_n high asynchronously); no resumption after release.
REQ-025 First start SHALL be accepted in the first cycle after rst_n deassertion.

Configuration
REQ-026 Macro SILIFE_READER_REVERSE_EN defined: frame data byte SHALL be cells bit-reversed (cells[0] sent first of data byte, in bit 7 position); header bits unchanged.
REQ-027 Macro SILIFE_READER_REVERSE_EN undefined: data byte SHALL be cells unmodified (cells[7] sent first).

Verification
REQ-028 Reset then start with CLK_DIV=2, NUM_ROWS=32 -> busy rises cycle 1, done pulse at cycle 2177, exactly 32 cs_n low windows of 64 cycles each.
REQ-029 Grid model returns cells = row index XOR 8'hA5, macro undefined -> row 3 frame decoded as 16'h03A6; row 31 as 16'h1FBA.
REQ-030 Same stimulus, SILIFE_READER_REVERSE_EN defined -> row 3 frame 16'h0365, row 0 frame 16'h00A5.
REQ-031 Second start pulse during row 5 of a scan -> ignored; exactly one done, no frame repeated or dropped.
REQ-032 en low for 10 cycles mid-bit of row 7 -> sclk/mosi/cs_n frozen; frame still decodes correctly; done delayed by exactly 10 cycles.
REQ-033 rst_n asserted during SHIFT of row 12 -> cs_n high same cycle, busy 0, row_select 0; subsequent start rescans from row 0.
